// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the pipeline and
// a debug/loader port, with starvation protection and incrementing debug bursts.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic [AW-1:0] p_A,
  input  logic [31:0]   p_WD,
  input  logic [1:0]    p_WE,
  output logic          p_stall,
  output logic [31:0]   p_rdata,
  output logic          p_rvalid,
  input  logic          d_req,
  input  logic [AW-1:0] d_A,
  input  logic [31:0]   d_WD,
  input  logic [1:0]    d_WE,
  input  logic [3:0]    d_len,
  output logic          d_gnt,
  output logic [31:0]   d_rdata,
  output logic          d_rvalid,
  output logic [AW-1:0] mem_A,
  output logic [31:0]   mem_WD,
  output logic [1:0]    mem_WE,
  input  logic [31:0]   mem_RD
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state, stateNext;
  logic [2:0]    starveCnt;
  logic [3:0]    beatsLeft;
  logic [3:0]    beatIdx;
  logic [AW-1:0] base;
  logic [AW-1:0] memAReg;
  logic          starved;
  logic          dWinIdle;
  logic          pGnt;

  assign starved  = 32'(starveCnt) >= STARVE_LIMIT;
  // Debug wins in IDLE when it is alone or has waited long enough.
  assign dWinIdle = ~rst & d_req & (~p_req | starved);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (rst) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (dWinIdle && d_len != 4'd0) stateNext = BURST;
        BURST:   if (!d_req || beatsLeft == 4'd1) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    pGnt   = 1'b0;
    d_gnt  = 1'b0;
    mem_A  = memAReg;
    mem_WD = 32'd0;
    mem_WE = 2'b00;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (dWinIdle) begin
            d_gnt  = 1'b1;
            mem_A  = d_A;
            mem_WD = d_WD;
            mem_WE = d_WE;
          end else if (p_req) begin
            pGnt   = 1'b1;
            mem_A  = p_A;
            mem_WD = p_WD;
            mem_WE = p_WE;
          end
        end
        BURST: begin
          if (d_req) begin
            d_gnt  = 1'b1;
            mem_A  = base + (AW'(beatIdx) << 2);
            mem_WD = d_WD;
            mem_WE = d_WE;
          end
        end
        default: ;
      endcase
    end
  end

  assign p_stall = ~rst & p_req & ~pGnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= 3'd0;
      beatsLeft <= 4'd0;
      beatIdx   <= 4'd0;
      base      <= '0;
      memAReg   <= '0;
      p_rdata   <= 32'd0;
      p_rvalid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_rvalid  <= 1'b0;
    end else begin
      memAReg <= mem_A;

      if (d_gnt || !d_req)       starveCnt <= 3'd0;
      else if (starveCnt != 3'd7) starveCnt <= starveCnt + 3'd1;

      // Beat 0 is issued from IDLE; later beats walk base by one word each.
      if (state == IDLE && d_gnt && d_len != 4'd0) begin
        base      <= d_A;
        beatsLeft <= d_len;
        beatIdx   <= 4'd1;
      end else if (state == BURST && d_gnt) begin
        beatsLeft <= beatsLeft - 4'd1;
        beatIdx   <= beatIdx + 4'd1;
      end

      p_rvalid <= pGnt && (p_WE == 2'b00);
      if (pGnt && p_WE == 2'b00) p_rdata <= mem_RD;

      d_rvalid <= d_gnt && (d_WE == 2'b00);
      if (d_gnt && d_WE == 2'b00) d_rdata <= mem_RD;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req;
  logic [31:0] p_A, p_WD;
  logic [1:0]  p_WE;
  logic        p_stall;
  logic [31:0] p_rdata;
  logic        p_rvalid;
  logic        d_req;
  logic [31:0] d_A, d_WD;
  logic [1:0]  d_WE;
  logic [3:0]  d_len;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic [31:0] mem_A, mem_WD;
  logic [1:0]  mem_WE;
  logic [31:0] mem_RD;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_A(p_A), .p_WD(p_WD), .p_WE(p_WE),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .d_req(d_req), .d_A(d_A), .d_WD(d_WD), .d_WE(d_WE), .d_len(d_len),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B9) ^ 32'h0BADF00D;
  endfunction

  assign mem_RD = memf(mem_A);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a burst is "next address + beats remaining".
  logic        mBurst = 1'b0;
  logic [31:0] mNext  = 32'd0;
  int          mLeft  = 0;
  int          mStarve = 0;
  logic [31:0] mMemA = 32'd0;
  logic        ePRv = 1'b0, eDRv = 1'b0;
  logic [31:0] ePRd = 32'd0, eDRd = 32'd0;
  bit          seen = 1'b0;

  always @(negedge clk) begin : model
    logic pg, dg;
    logic [31:0] a, wd;
    logic [1:0] we;
    pg = 1'b0; dg = 1'b0; a = mMemA; wd = 32'd0; we = 2'b00;
    if (!rst) begin
      if (mBurst) begin
        if (d_req) begin dg = 1'b1; a = mNext; wd = d_WD; we = d_WE; end
      end else if (d_req && (!p_req || mStarve >= LIMIT)) begin
        dg = 1'b1; a = d_A; wd = d_WD; we = d_WE;
      end else if (p_req) begin
        pg = 1'b1; a = p_A; wd = p_WD; we = p_WE;
      end
    end
    if (seen) begin
      chk("m_p_stall",  64'(p_stall),  64'(!rst && p_req && !pg));
      chk("m_d_gnt",    64'(d_gnt),    64'(dg));
      chk("m_mem_A",    64'(mem_A),    64'(a));
      chk("m_mem_WD",   64'(mem_WD),   64'(wd));
      chk("m_mem_WE",   64'(mem_WE),   64'(we));
      chk("m_p_rvalid", 64'(p_rvalid), 64'(ePRv));
      chk("m_p_rdata",  64'(p_rdata),  64'(ePRd));
      chk("m_d_rvalid", 64'(d_rvalid), 64'(eDRv));
      chk("m_d_rdata",  64'(d_rdata),  64'(eDRd));
    end
    if (rst) begin
      mBurst = 1'b0; mStarve = 0; mMemA = 32'd0;
      ePRv = 1'b0; eDRv = 1'b0; ePRd = 32'd0; eDRd = 32'd0;
      seen = 1'b1;
    end else begin
      mMemA = a;
      ePRv = pg && (p_WE == 2'b00);
      if (ePRv) ePRd = memf(a);
      eDRv = dg && (d_WE == 2'b00);
      if (eDRv) eDRd = memf(a);
      mStarve = (dg || !d_req) ? 0 : ((mStarve < 7) ? mStarve + 1 : 7);
      if (mBurst) begin
        if (!d_req) mBurst = 1'b0;
        else begin
          mLeft--;
          mNext = mNext + 32'd4;
          if (mLeft == 0) mBurst = 1'b0;
        end
      end else if (dg && d_len != 4'd0) begin
        mBurst = 1'b1;
        mLeft  = int'(d_len);
        mNext  = d_A + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic allIdle();
    rst = 1'b0; p_req = 1'b0; d_req = 1'b0;
    p_A = 32'd0; p_WD = 32'd0; p_WE = 2'b00;
    d_A = 32'd0; d_WD = 32'd0; d_WE = 2'b00; d_len = 4'd0;
  endtask

  logic [31:0] burstA [4];
  bit          dActive;
  int          beats;
  logic [3:0]  len;
  logic        g;

  initial begin
    allIdle();
    // Reset: requests present but everything suppressed.
    rst = 1'b1; p_req = 1'b1; d_req = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_p_stall", 64'(p_stall), 64'd0);
    chk("rst_d_gnt",   64'(d_gnt),   64'd0);
    chk("rst_mem_WE",  64'(mem_WE),  64'd0);
    tick();
    allIdle();
    @(negedge clk);
    chk("rst_p_rvalid", 64'(p_rvalid), 64'd0);
    chk("rst_p_rdata",  64'(p_rdata),  64'd0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rst_mem_A",    64'(mem_A),    64'd0);

    // Pipeline-only read.
    tick();
    p_req = 1'b1; p_A = 32'h10; p_WE = 2'b00;
    @(negedge clk);
    chk("prd_stall", 64'(p_stall), 64'd0);
    chk("prd_mem_A", 64'(mem_A),   64'h10);
    tick();
    p_req = 1'b0;
    @(negedge clk);
    chk("prd_rvalid", 64'(p_rvalid), 64'd1);
    chk("prd_rdata",  64'(p_rdata),  64'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("prd_rvalid_low", 64'(p_rvalid), 64'd0);
    chk("prd_rdata_hold", 64'(p_rdata),  64'hDEADBEEF);

    // Starvation: pipeline wins four times, then debug once.
    tick();
    p_req = 1'b1; p_A = 32'h40; p_WE = 2'b11;
    d_req = 1'b1; d_A = 32'h80; d_WE = 2'b11; d_len = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("starve_d_gnt_%0d", i),   64'(d_gnt),   64'(i == 5));
      chk($sformatf("starve_p_stall_%0d", i), 64'(p_stall), 64'(i == 5));
      tick();
    end
    allIdle();

    // Four-beat write burst at 0x100.
    tick();
    burstA = '{32'h100, 32'h104, 32'h108, 32'h10C};
    d_req = 1'b1; d_A = 32'h100; d_len = 4'd3; d_WE = 2'b11;
    for (int i = 0; i < 4; i++) begin
      d_WD = $urandom;
      @(negedge clk);
      chk($sformatf("burst_gnt_%0d", i),   64'(d_gnt), 64'd1);
      chk($sformatf("burst_mem_A_%0d", i), 64'(mem_A), 64'(burstA[i]));
      if (i > 0) chk($sformatf("burst_stall_%0d", i), 64'(p_stall), 64'd1);
      tick();
      p_req = 1'b1; p_A = 32'h44; p_WE = 2'b01;
    end
    d_req = 1'b0;
    @(negedge clk);
    chk("burst_done_gnt",   64'(d_gnt),   64'd0);
    chk("burst_done_stall", 64'(p_stall), 64'd0);
    tick();
    allIdle();

    // Address wrap on the second beat.
    tick();
    d_req = 1'b1; d_A = 32'hFFFF_FFFC; d_len = 4'd1; d_WE = 2'b00;
    @(negedge clk);
    chk("wrap_mem_A_0", 64'(mem_A), 64'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_mem_A_1", 64'(mem_A), 64'h0);
    chk("wrap_gnt_1",   64'(d_gnt), 64'd1);
    tick();
    allIdle();

    // Debug drops out after two beats of an eight-beat burst.
    tick();
    d_req = 1'b1; d_A = 32'h200; d_len = 4'd7; d_WE = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort_gnt_%0d", i), 64'(d_gnt), 64'd1);
      tick();
    end
    d_req = 1'b0; p_req = 1'b1; p_A = 32'h60; p_WE = 2'b11;
    @(negedge clk);
    chk("abort_no_beat", 64'(d_gnt),  64'd0);
    chk("abort_we",      64'(mem_WE), 64'd0);
    tick();
    @(negedge clk);
    chk("abort_p_stall", 64'(p_stall), 64'd0);
    chk("abort_p_mem_A", 64'(mem_A),   64'h60);
    tick();
    allIdle();

    // Reset during the second beat of a read burst.
    tick();
    d_req = 1'b1; d_A = 32'h300; d_len = 4'd3; d_WE = 2'b00;
    @(negedge clk);
    chk("rstb_gnt_0", 64'(d_gnt), 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstb_gnt_1", 64'(d_gnt),  64'd0);
    chk("rstb_we_1",  64'(mem_WE), 64'd0);
    tick();
    allIdle();
    @(negedge clk);
    chk("rstb_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rstb_d_rdata",  64'(d_rdata),  64'd0);
    chk("rstb_p_rdata",  64'(p_rdata),  64'd0);
    chk("rstb_mem_A",    64'(mem_A),    64'd0);
    tick();
    d_req = 1'b1; d_len = 4'd0; p_req = 1'b1; p_WE = 2'b11;
    @(negedge clk);
    chk("rstb_idle_p_stall", 64'(p_stall), 64'd0);
    chk("rstb_idle_d_gnt",   64'(d_gnt),   64'd0);
    tick();
    allIdle();

    // Randomized traffic; the model process checks every cycle.
    dActive = 1'b0; beats = 0; len = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      g = d_gnt;
      tick();
      if (dActive) begin
        if (g) beats++;
        if (beats == int'(len) + 1 || (beats > 0 && $urandom_range(0, 15) == 0))
          dActive = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        dActive = 1'b1;
        beats   = 0;
        len     = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
        d_A     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      end
      d_req = dActive;
      d_len = len;
      d_WD  = $urandom;
      d_WE  = 2'($urandom_range(0, 3));
      p_req = ($urandom_range(0, 9) < 7);
      p_A   = $urandom & 32'hFFFF_FFFC;
      p_WD  = $urandom;
      p_WE  = 2'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 199) == 0);
    end
    allIdle();
    tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
